// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default widths for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2} fetch_state_t;
    localparam int DEFAULT_INSTRUCTION_WIDTH = 40;
    localparam int DEFAULT_PC_WIDTH = 5;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with load/increment/hold; wrap flags the last address
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                inc,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                wrap
);
    assign wrap = &pc;
    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= '0;
        else if (load) pc <= target;
        else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pc ownership, instruction register and decode handshake.
// FETCH_WRAP_FAULT_EN turns the end-of-space wrap into a sticky fault that halts fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH-1:0]          pc,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    output logic [INSTRUCTION_WIDTH-1:0] ir,
    output logic [PC_WIDTH-1:0]          ir_pc,
    output logic                         ir_valid,
    input  logic                         ir_ready,
    input  logic                         jump,
    input  logic [PC_WIDTH-1:0]          jump_target,
    input  logic                         halt,
    output logic                         halted,
    output logic                         fault
);
`ifdef FETCH_WRAP_FAULT_EN
    localparam bit WRAP_FAULT = 1'b1;
`else
    localparam bit WRAP_FAULT = 1'b0;
`endif
    fetch_state_t state;
    logic run, fetch, load, trap, wrap;
    assign run = state == S_RUN && !halt;
    assign fetch = run && !jump && (!ir_valid || ir_ready);
    assign load = run && jump;
    assign trap = WRAP_FAULT && fetch && wrap;
    assign halted = state == S_HALTED;
    fetch_pc_reg #(.PC_WIDTH(PC_WIDTH)) u_pc (
        .clk(clk),
        .rst(rst),
        .load(load),
        .inc(fetch && !trap),
        .target(jump_target),
        .pc(pc),
        .wrap(wrap)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_BOOT;
            ir <= '0;
            ir_pc <= '0;
            ir_valid <= 1'b0;
        end else if (state == S_BOOT) begin
            state <= halt ? S_HALTED : S_RUN;
        end else if (state == S_HALTED || halt) begin
            state <= S_HALTED;
            if (ir_ready) ir_valid <= 1'b0;
        end else if (jump) begin
            ir_valid <= 1'b0;
        end else if (fetch) begin
            ir <= instr_in;
            ir_pc <= pc;
            ir_valid <= 1'b1;
            if (trap) state <= S_HALTED;
        end
`ifdef FETCH_WRAP_FAULT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) fault <= 1'b0;
        else if (trap) fault <= 1'b1;
`else
    assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of startup, stall, jump, wrap/fault, async reset and halt
module tb_fetch_unit;
    import fetch_pkg::*;
`ifdef FETCH_WRAP_FAULT_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, ir_ready = 1'b1, jump = 1'b0, halt = 1'b0;
    logic [4:0] pc, ir_pc, jump_target = '0;
    logic [39:0] instr_in, ir;
    logic ir_valid, halted, fault;
    logic [39:0] mem [32];
    int n_assert = 0, n_fail = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .instr_in(instr_in), .ir(ir), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .jump(jump), .jump_target(jump_target),
        .halt(halt), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;
    assign instr_in = mem[pc];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic startup();
        @(negedge clk);
        chk("boot_valid", 64'(ir_valid), 64'd0);
        chk("boot_pc", 64'(pc), 64'd0);
        @(negedge clk);
        chk("first_valid", 64'(ir_valid), 64'd1);
        chk("first_ir", 64'(ir), 64'h100);
        chk("first_ir_pc", 64'(ir_pc), 64'd0);
        chk("first_pc", 64'(pc), 64'd1);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 40'(k + 'h100);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_ir", 64'(ir), 64'd0);
        chk("rst_valid", 64'(ir_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        rst = 1'b0;
        startup();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("seq_ir", 64'(ir), 64'('h100 + k));
            chk("seq_ir_pc", 64'(ir_pc), 64'(k));
        end
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ir", 64'(ir), 64'h104);
            chk("stall_ir_pc", 64'(ir_pc), 64'd4);
            chk("stall_pc", 64'(pc), 64'd5);
            chk("stall_valid", 64'(ir_valid), 64'd1);
        end
        ir_ready = 1'b1;
        @(negedge clk);
        chk("resume_ir_pc", 64'(ir_pc), 64'd5);
        chk("resume_ir", 64'(ir), 64'h105);
        ir_ready = 1'b0;
        jump = 1'b1;
        jump_target = 5'd20;
        @(negedge clk);
        chk("jump_flush", 64'(ir_valid), 64'd0);
        chk("jump_pc", 64'(pc), 64'd20);
        jump = 1'b0;
        ir_ready = 1'b1;
        @(negedge clk);
        chk("jump_ir", 64'(ir), 64'h114);
        chk("jump_ir_pc", 64'(ir_pc), 64'd20);
        chk("jump_valid", 64'(ir_valid), 64'd1);
        for (int k = 21; k <= 31; k++) begin
            @(negedge clk);
            chk("run_ir_pc", 64'(ir_pc), 64'(k));
        end
        chk("end_ir", 64'(ir), 64'h11f);
        chk("end_pc", 64'(pc), WF ? 64'd31 : 64'd0);
        chk("end_halted", 64'(halted), 64'(WF));
        chk("end_fault", 64'(fault), 64'(WF));
        @(negedge clk);
        chk("wrap_valid", 64'(ir_valid), WF ? 64'd0 : 64'd1);
        chk("wrap_ir_pc", 64'(ir_pc), WF ? 64'd31 : 64'd0);
        chk("wrap_pc", 64'(pc), WF ? 64'd31 : 64'd1);
        chk("wrap_fault", 64'(fault), 64'(WF));
        rst = 1'b1;
        #1;
        chk("rst2_fault", 64'(fault), 64'd0);
        chk("rst2_halted", 64'(halted), 64'd0);
        chk("rst2_pc", 64'(pc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        startup();
        for (int k = 1; k <= 8; k++) @(negedge clk);
        chk("pre_rst_pc", 64'(pc), 64'd9);
        chk("pre_rst_ir_pc", 64'(ir_pc), 64'd8);
        rst = 1'b1;
        #1;
        chk("async_pc", 64'(pc), 64'd0);
        chk("async_valid", 64'(ir_valid), 64'd0);
        chk("async_fault", 64'(fault), 64'd0);
        chk("async_ir", 64'(ir), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        startup();
        ir_ready = 1'b0;
        jump = 1'b1;
        halt = 1'b1;
        jump_target = 5'd20;
        @(negedge clk);
        chk("jh_halted", 64'(halted), 64'd1);
        chk("jh_pc", 64'(pc), 64'd1);
        chk("jh_valid", 64'(ir_valid), 64'd1);
        chk("jh_ir_pc", 64'(ir_pc), 64'd0);
        jump = 1'b0;
        halt = 1'b0;
        ir_ready = 1'b1;
        @(negedge clk);
        chk("halt_consumed", 64'(ir_valid), 64'd0);
        chk("halt_pc", 64'(pc), 64'd1);
        @(negedge clk);
        chk("halt_idle", 64'(ir_valid), 64'd0);
        chk("halt_sticky", 64'(halted), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter, drives the memory address, and latches the returned 40-bit instruction into an instruction register. The register is handed to decode through a valid/ready handshake. Handles sequential increment, jump redirection with flush, decode back-pressure and halt.

## Interface
Parameters:
- INSTRUCTION_WIDTH, 40, width of one instruction word
- PC_WIDTH, 5, program-counter width; address space 2^PC_WIDTH words

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- pc  output  PC_WIDTH  address to instruction memory (memory read is combinational)
- instr_in  input  INSTRUCTION_WIDTH  memory data for the current pc, valid in the same cycle
- ir  output  INSTRUCTION_WIDTH  latched instruction for decode
- ir_pc  output  PC_WIDTH  address the instruction in ir was fetched from
- ir_valid  output  1  ir holds an instruction not yet consumed
- ir_ready  input  1  decode accepts ir this cycle when ir_valid=1
- jump  input  1  redirect request from execute
- jump_target  input  PC_WIDTH  new pc when jump=1
- halt  input  1  stop fetching
- halted  output  1  fetch stopped (state HALTED)
- fault  output  1  pc end-of-space trap (see Configuration)

## Operation
- States: BOOT, RUN, HALTED.
- Reset values: state=BOOT, pc=0, ir=0, ir_pc=0, ir_valid=0, halted=0, fault=0.
- BOOT:
  - One cycle with no fetch.
  - Goes to RUN unconditionally unless halt=1, in which case it goes to HALTED.
- RUN, fetch condition: fetch_en = !ir_valid || ir_ready.
- RUN, event priority per cycle, highest first:
  - halt=1: next state HALTED; no fetch; pc holds; ir_valid clears if ir_ready=1, else holds until consumed.
  - jump=1: pc <= jump_target; ir_valid <= 0 (flush, even if ir_ready=0); no fetch this cycle.
  - fetch_en=1: ir <= instr_in; ir_pc <= pc; ir_valid <= 1; pc <= pc+1 modulo 2^PC_WIDTH (carry discarded).
  - otherwise (ir_valid=1, ir_ready=0): all registers hold.
- HALTED:
  - No fetch; jump ignored; pc holds; halted=1.
  - ir_valid clears on its handshake.
  - Exits only via rst.
- Handshake rule: once ir_valid=1, ir and ir_pc are stable until the cycle ir_ready=1 or a flush.
- Reset mid-operation: all registers return to reset values immediately and asynchronously; an in-flight ir is lost.

## Timing
- Fetch latency: pc=N in cycle t gives ir=mem[N], ir_valid=1 in cycle t+1.
- First instruction:
  - rst deasserts before edge 0; cycle 0 is BOOT.
  - Cycle 1 fetches pc=0.
  - ir_valid=1 with mem[0] from cycle 2.
- Throughput: one instruction per cycle while ir_ready=1.
- Jump:
  - jump asserted in cycle t gives pc=target in t+1.
  - Fetch happens in t+1; ir=mem[target] valid in t+2.
  - Exactly one bubble cycle.
- halted rises the cycle after halt is sampled.

## Configuration
- FETCH_WRAP_FAULT_EN undefined:
  - pc wraps from 2^PC_WIDTH-1 to 0.
  - fault tied to 0.
- FETCH_WRAP_FAULT_EN defined:
  - A fetch at pc=2^PC_WIDTH-1 still delivers that instruction normally.
  - On that same edge the state goes to HALTED, fault <= 1 and pc holds at max instead of wrapping.
  - A jump in the same cycle takes priority (no fetch, no fault).
  - fault is sticky until rst.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum (BOOT, RUN, HALTED)
  - default INSTRUCTION_WIDTH and PC_WIDTH constants
- Sub-module fetch_pc_reg:
  - pc register with load (jump), increment and hold controls
  - emits a wrap flag used by the FETCH_WRAP_FAULT_EN logic

## Test plan
- Reset release, memory preloaded with mem[k]=k+0x100, ir_ready=1 → ir_valid first high in cycle 2 with ir=0x100, ir_pc=0; then ir=0x101, 0x102… one per cycle.
- ir_ready=0 for 3 cycles while ir_valid=1 at ir_pc=4 → ir, ir_pc and pc=5 stable for all 3 cycles; ir_pc=5 delivered the cycle after ir_ready returns to 1.
- jump=1, jump_target=20 while ir_valid=1 and ir_ready=0 → next cycle ir_valid=0, pc=20; the cycle after, ir=mem[20], ir_pc=20.
- jump and halt asserted in the same cycle → state HALTED, pc unchanged, halted=1 next cycle, no further ir_valid after the current ir is consumed.
- Sequential run to pc=31 without the macro → ir_pc goes 31 then 0; with FETCH_WRAP_FAULT_EN → ir_pc=31 delivered, then halted=1, fault=1, pc=31.
- rst pulsed mid-run at pc=9 with ir_valid=1 → immediately pc=0, ir_valid=0, fault=0, state BOOT; the normal startup sequence repeats.
